// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line-level constants shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: holds the accepted word and walks the LSB-first bit index, presenting the bit for the next line cycle
module uart_tx_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] word,
  output logic             data_bit,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  // the index sits at zero outside DATA so entry always starts at bit 0, and it parks on the last bit instead of wrapping
  assign last     = cnt == LAST;
  assign cnt_nxt  = !shift ? '0 : last ? cnt : cnt + 1'b1;
  assign data_bit = word[cnt_nxt];
  // word is captured only on accept; the index follows the FSM every cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else begin
      if (load) word <= data_in;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame transmitter (start, LSB-first data, optional parity, stop); parity built only when UART_TX_PARITY_EN is defined
module uart_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);
  import uart_pkg::*;
  state_t           state;
  logic             accept;
  logic             data_bit;
  logic             last;
  logic [WIDTH-1:0] word;
  assign accept = Data_Valid && !Busy;
  uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk      (CLK),
    .rst_n    (Reset),
    .load     (accept),
    .shift    (state == DATA),
    .data_in  (P_DATA),
    .word     (word),
    .data_bit (data_bit),
    .last     (last)
  );
`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_bit;
  assign par_bit = (^word) ^ (par_typ_q == PAR_ODD);
  // parity options are frozen per frame at accept time
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
`else
  logic unused_par;
  assign unused_par = ^{PAR_EN, PAR_TYP, word};
`endif
  // frame sequencer; TX_OUT and Busy are registered with the value for the state being entered
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state  <= IDLE;
      TX_OUT <= STOP_BIT;
      Busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, STOP: begin
          state  <= accept ? START : IDLE;
          TX_OUT <= accept ? START_BIT : STOP_BIT;
          Busy   <= accept;
        end
        START: begin
          state  <= DATA;
          TX_OUT <= data_bit;
          Busy   <= 1'b1;
        end
        DATA: begin
          if (!last) TX_OUT <= data_bit;
`ifdef UART_TX_PARITY_EN
          else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_bit;
          end
`endif
          else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
          Busy   <= 1'b0;
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          Busy   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx, expectations follow UART_TX_PARITY_EN
module tb_uart_tx;
  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  int checks = 0;
  int errors = 0;
  uart_tx #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    check({tag, " idle tx"}, TX_OUT, 1);
    check({tag, " idle busy"}, Busy, 0);
  endtask
  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Data_Valid = 1'b1;
    @(negedge CLK);
  endtask
  task automatic run(input string tag, input int n, input logic [31:0] tx_e, input logic [31:0] busy_e,
                     input int dv_off, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), TX_OUT, tx_e[n-1-i]);
      check($sformatf("%s busy[%0d]", tag, i), Busy, busy_e[n-1-i]);
      if (i == dv_off) Data_Valid = 1'b0;
      if (i == pulse_at + 1) Data_Valid = 1'b0;
      if (i == pulse_at) begin
        Data_Valid = 1'b1;
        P_DATA = 8'h55;
      end
      @(negedge CLK);
    end
  endtask
  initial begin
    @(negedge CLK);
    chk_idle("in_reset");
    Reset = 1'b1;
    start(8'hA5, 1'b0, 1'b0);
    run("a5_nopar", 10, 32'b0101001011, 32'b1111111110, 0, 999);
    chk_idle("a5_nopar");
`ifdef UART_TX_PARITY_EN
    start(8'hA5, 1'b1, 1'b0);
    run("a5_even", 11, 32'b01010010101, 32'b11111111110, 0, 999);
    chk_idle("a5_even");
    start(8'hA5, 1'b1, 1'b1);
    run("a5_odd", 11, 32'b01010010111, 32'b11111111110, 0, 999);
    chk_idle("a5_odd");
    start(8'hFF, 1'b1, 1'b0);
    run("ff_par", 11, 32'b01111111101, 32'b11111111110, 0, 999);
    chk_idle("ff_par");
`else
    start(8'hA5, 1'b1, 1'b1);
    run("a5_ignpar", 10, 32'b0101001011, 32'b1111111110, 0, 999);
    chk_idle("a5_ignpar");
    start(8'hFF, 1'b1, 1'b0);
    run("ff_nopar", 10, 32'b0111111111, 32'b1111111110, 0, 999);
    chk_idle("ff_nopar");
`endif
    start(8'h01, 1'b0, 1'b0);
    P_DATA = 8'hFF;
    run("b2b", 20, 32'b01000000010111111111, 32'b11111111101111111110, 10, 999);
    chk_idle("b2b");
    start(8'h0F, 1'b0, 1'b0);
    run("ignore", 10, 32'b0111100001, 32'b1111111110, 0, 3);
    chk_idle("ignore");
    @(negedge CLK);
    chk_idle("ignore2");
    #2 Reset = 1'b0;
    #1 chk_idle("rst_idle");
    @(negedge CLK);
    Reset = 1'b1;
    start(8'h00, 1'b0, 1'b0);
    run("rst_pre", 5, 32'b00000, 32'b11111, 0, 999);
    check("rst_bit4 tx", TX_OUT, 0);
    check("rst_bit4 busy", Busy, 1);
    #2 Reset = 1'b0;
    #1 chk_idle("rst_mid");
    @(negedge CLK);
    chk_idle("rst_held");
    Reset = 1'b1;
    start(8'h3C, 1'b0, 1'b0);
    run("after_rst", 10, 32'b0001111001, 32'b1111111110, 0, 999);
    chk_idle("after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
